// File: rtl/uart_imem_loader_pkg.sv
// uart_imem_loader_pkg
//   Shared constants for the UART instruction-memory loader: RX FSM state
//   encoding, 8N1 framing constants and the baud divisor computation.
package uart_imem_loader_pkg;

    // RX FSM encoding
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam int DATA_BITS = 8;

    // Clocks per UART bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver with a 2-FF input synchroniser.
//   Ports:
//     clk, rst     system clock, async active-low reset
//     rx           raw UART line (asynchronous)
//     enable       synchronised load-mode level; gates new start bits only
//     rx_byte      last received byte (LSB first on the wire)
//     byte_valid   1-cycle pulse at the stop-bit sample when stop = 1
//     byte_err     1-cycle pulse at the stop-bit sample when stop = 0
//     busy         FSM not idle
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       busy
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             rx_meta, rx_s, rx_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             tick;

    // Start state samples at half a bit to land mid-bit for the rest.
    assign tick       = (cnt == ((state == RX_START) ? HALF_CNT : FULL_CNT));
    // Combinational so the word strobe can follow the stop sample by one clk.
    assign byte_valid = (state == RX_STOP) && tick && rx_s;
    assign byte_err   = (state == RX_STOP) && tick && !rx_s;
    assign busy       = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (enable && rx_q && !rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // High at mid start bit means a glitch: drop silently.
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin // RX_STOP
                    if (tick) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Receives bytes over UART, packs them little-endian into 32-bit words and
//   writes them to sequential instruction-memory addresses while holding the
//   CPU in reset.
//   Ports:
//     clk, rst     system clock, async active-low reset
//     rx           raw UART line
//     load_en      load-mode request level (switch)
//     we           one-cycle write strobe per completed word
//     waddr        word address of the current write
//     wdata        assembled word
//     cpu_hold     processor reset request
//     word_cnt     words written this session
//     frame_err    sticky: a byte had a bad stop bit
//     full         sticky: last address has been written
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_en,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_cnt,
    output logic              frame_err,
    output logic              full
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic       load_meta, load_s, load_q, load_rise;
    logic [7:0] rx_byte;
    logic       byte_valid, byte_err, busy;
    logic [1:0] byte_idx;
    logic       word_done;

    assign load_rise = load_s && !load_q;
    // we doubles as the pending-write flag so hold outlives the strobe.
    assign cpu_hold  = load_s || busy || we;

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .enable     (load_s),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .busy       (busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_meta <= 1'b0;
            load_s    <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            load_meta <= load_en;
            load_s    <= load_meta;
            load_q    <= load_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we        <= 1'b0;
            word_done <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            word_cnt  <= '0;
            frame_err <= 1'b0;
            full      <= 1'b0;
            byte_idx  <= '0;
        end else begin
            we        <= 1'b0;
            word_done <= 1'b0;
            if (load_rise) begin
                waddr     <= '0;
                word_cnt  <= '0;
                byte_idx  <= '0;
                frame_err <= 1'b0;
                full      <= 1'b0;
            end else begin
                if (byte_err) begin
                    frame_err <= 1'b1;
                    byte_idx  <= '0;
                end else if (byte_valid) begin
                    wdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
                    if (byte_idx == 2'd3) begin
                        word_done <= 1'b1;
                        // Once full, words are still received but not written.
                        we        <= !full;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                if (word_done) begin
                    byte_idx <= '0;
                    if (we) begin
                        word_cnt <= word_cnt + CNT_ONE;
                        if (waddr == LAST_ADDR) full  <= 1'b1;
                        else                    waddr <= waddr + ADDR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Serial program loader that sits upstream of the instruction memory. It receives bytes on the board UART RX line, packs them little-endian into 32-bit instruction words, and issues one write strobe per word with a sequential word address. While loading, it holds the processor in reset so that new firmware can be downloaded without resynthesis.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; 8N1 framing, LSB first
ADDR_W, 6, instruction-memory word-address width (64 words)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  reset, asynchronous, active-low
rx  in  1  raw UART receive line, asynchronous to clk
load_en  in  1  level request for load mode (switch), asynchronous
we  out  1  instruction-memory write strobe, one clk pulse per word
waddr  out  ADDR_W  word address for the current write
wdata  out  32  assembled instruction word
cpu_hold  out  1  high = processor PC/register file held in reset
word_cnt  out  ADDR_W+1  number of words written in the current session
frame_err  out  1  sticky; a byte had stop bit = 0
full  out  1  sticky; all 2^ADDR_W words written

Behaviour:
- Reset (rst=0, asynchronous): we=0, waddr=0, wdata=0, word_cnt=0, frame_err=0, full=0, cpu_hold=0, RX FSM=IDLE, byte index=0. The rx and load_en synchronisers reset to 1 and 0 respectively.
- rx and load_en pass through 2-FF synchronisers. Edge detection uses the synchronised signals only.
- DIV = (CLK_HZ + BAUD/2)/BAUD. With default parameters, DIV = 434. The bit counter is wide enough for DIV-1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised rx falling edge, only while load mode is active.
  - START: wait DIV/2 cycles, then resample. If rx=0, go to DATA; otherwise this is a glitch, return to IDLE with no error.
  - DATA: sample every DIV cycles, 8 bits, LSB first, shifted into a byte register.
  - STOP: sample after DIV cycles.
    - rx=1: the byte is accepted.
    - rx=0: the byte is discarded, frame_err is set, byte index clears to 0 (partial word dropped).
  - STOP -> IDLE in both cases.
- Word assembly: an accepted byte k (k=0..3) is written to wdata[8k+7:8k]. The fourth byte completes the word.
  - In the cycle after the fourth byte is accepted: we=1 for exactly 1 cycle, with waddr and wdata stable.
  - In the following cycle: waddr increments, word_cnt increments, byte index returns to 0.
  - wdata holds its value until the next byte is accepted.
- Full: the write to address 2^ADDR_W-1 sets full. waddr does not wrap. Further complete words produce no strobe, but their bytes are still received.
- Load session:
  - Rising edge of synchronised load_en: waddr, word_cnt, byte index, frame_err and full are cleared; cpu_hold=1.
  - cpu_hold = synchronised load_en, OR-ed with FSM not IDLE, OR-ed with a pending write. Hold releases only after any in-flight strobe has completed.
- load_en falling mid-byte: the FSM finishes the current byte, including STOP. If that byte completes a word, the write occurs. Otherwise the partial word is discarded; the byte index clears on the next session start. No new start bit is accepted after the fall.
- When load_en is low: the rx line is ignored, we stays 0, and the status outputs hold their values for display.
- Latency: from the mid-point of the stop bit of byte 3 to we=1 is exactly 1 clk.

Decomposition:
- Shared package holds:
  - the RX state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the DIV computation function;
  - the 8N1 constants (DATA_BITS=8).
- One natural sub-module: uart_rx_byte. It contains the synchroniser, baud counter and FSM, and outputs byte[7:0], byte_valid (1-cycle pulse), byte_err and busy. The word packer, address counter and hold logic stay in uart_imem_loader.

Test Plan:
1. load_en=1, then bytes 0x13 0x05 0x50 0x00 at 115200 baud -> one we pulse with waddr=0, wdata=0x00500513; word_cnt=1; cpu_hold=1 throughout.
2. Two words back-to-back, 0x00500513 then 0x00A00593 -> strobes at waddr 0 and 1; word_cnt=2; no extra strobes.
3. Byte with stop bit forced 0 after 2 good bytes -> no we, frame_err=1. The next 4 good bytes are written at waddr=0 with correct wdata.
4. 3-cycle low glitch on rx while idle -> no byte, no error, FSM back in IDLE. Also: rx held high with load_en=0 while a byte is sent -> we never asserts.
5. ADDR_W=2, send 5 words -> strobes at addresses 0..3, full=1, fifth word not written, word_cnt=4. A new load_en rising edge clears full and word_cnt.
6. Assert rst low mid-DATA of byte 2 -> all outputs go to reset values immediately. After release with load_en=1, a fresh 4-byte word writes at waddr=0.
